trap_ctrl_rv32: RTL and testbench
=================================

// Module: trap_ctrl_rv32
// PURPOSE
// Machine-mode trap sequencer for the RV32 core. It drives the mstatus MIE/MPIE stack:
// mie_clear_out on trap entry, mie_set_out on MRET.
// Arbitrates interrupts and synchronous exceptions at instruction boundaries, and produces
// mcause/mepc write strobes, the redirect PC and a pipeline flush.
// Sits between the decode/execute stage and the CSR file.
// PARAMETERS
// VECTORED   0   1: interrupt redirect = {mtvec_in[31:2],2'b00} + 4*code; exceptions always use base
// MEPC_ALIGN 1   1: force epc_out[1:0]=2'b00
// PORTS
// clk_in           in   1   core clock
// rst_in           in   1   asynchronous, active-low reset
// instr_valid_in   in   1   instruction at pc_in is at commit boundary this cycle
// stall_in         in   1   pipeline stalled; FSM holds state, no new decision
// pc_in            in   32  PC of the boundary instruction
// mtvec_in         in   32  mtvec CSR value
// mie_in           in   1   mstatus.MIE (global enable)
// meie_in,msie_in,mtie_in  in 1 each  mie CSR per-source enables
// meip_in,msip_in,mtip_in  in 1 each  pending external/software/timer interrupts
// illegal_in,ecall_in,ebreak_in,ialign_in,lalign_in,salign_in  in 1 each  exception flags
// mret_in          in   1   boundary instruction is MRET
// mepc_in          in   32  current mepc CSR value
// mie_clear_out    out  1   pulse: push MIE->MPIE, MIE=0
// mie_set_out      out  1   pulse: MIE=MPIE, MPIE=1
// cause_we_out     out  1   write mcause
// cause_out        out  32  mcause value
// epc_we_out       out  1   write mepc
// epc_out          out  32  mepc value
// redirect_out     out  1   pulse: load PC from redirect_pc_out
// redirect_pc_out  out  32  target PC
// flush_out        out  1   squash younger instructions
// busy_out         out  1   FSM not in RUN
// BEHAVIOUR
// - States: RUN, ENTER, RETURN, DRAIN. All outputs are registered; strobes are 1-cycle pulses.
// - Reset (rst_in=0, asynchronous): state=RUN. All strobes, busy_out, cause_out, epc_out
//   and redirect_pc_out are 0.
// - RUN: decisions are made only when instr_valid_in=1 and stall_in=0.
//   Priority is interrupt > exception > MRET.
// - Interrupt taken iff mie_in & (meip&meie | msip&msie | mtip&mtie).
//   Source order is MEI(11) > MSI(3) > MTI(7). cause={1'b1,27'b0,code}.
//   The boundary instruction is not executed; epc=pc_in.
// - Exception order, cause={1'b0,...}: ialign(0) > illegal(2) > ebreak(3) > ecall(11)
//   > lalign(4) > salign(6). epc=pc_in. Exceptions are taken regardless of mie_in.
// - Trap decided at edge N -> ENTER during cycle N+1. In ENTER, mie_clear_out, cause_we_out,
//   epc_we_out, redirect_out, flush_out and busy_out are all 1.
//   redirect_pc_out = base, or vectored address for interrupts when VECTORED=1.
// - MRET decided at edge N -> RETURN during cycle N+1. In RETURN, mie_set_out, redirect_out,
//   flush_out and busy_out are 1, with redirect_pc_out=mepc_in.
//   RETURN never writes mcause or mepc.
// - ENTER/RETURN -> DRAIN (1 cycle, busy_out=1, all strobes 0, inputs ignored) -> RUN.
//   The drain cycle lets the mstatus update settle, so mie_in is observed post-update.
// - stall_in in ENTER/RETURN/DRAIN is ignored: the sequence always completes.
// - Interrupt arriving in the same cycle as MRET or an exception: the interrupt wins.
//   The MRET is not performed, and mie_set_out is never asserted with mie_clear_out.
// - Interrupt pending while mie_in=0: no action. Sampled again every boundary cycle.
// - Exception inside a trap handler (mie_in=0): taken normally; nested MPIE is overwritten
//   per mstatus semantics.
// - Reset asserted mid-sequence: immediate return to RUN, all strobes 0 within the same cycle.
// - cause_out/epc_out hold their last value outside ENTER. cause_out[30:4]=0 always.
// TESTING
// - T1 Reset: rst_in=0 mid-ENTER -> all outputs 0 asynchronously; RUN after release.
// - T2 Timer IRQ: mie_in=1, mtie=1, mtip=1, pc_in=0x100, mtvec_in=0x800, VECTORED=0.
//   -> 1 cycle later mie_clear_out=1, cause_out=0x80000007, epc_out=0x100,
//   redirect_pc_out=0x800. Then DRAIN, then RUN.
// - T3 Vectored MEI: VECTORED=1, mtvec_in=0x801, meip=meie=1 -> redirect_pc_out=0x82C,
//   cause_out=0x8000000B.
// - T4 Illegal with mie_in=0: illegal_in=1, pc_in=0x44 -> cause_out=0x2, epc_out=0x44,
//   mie_clear_out=1. A pending MTI in the same cycle is ignored.
// - T5 MRET: mret_in=1, mepc_in=0x104 -> mie_set_out=1, redirect_pc_out=0x104,
//   cause_we_out=0 and epc_we_out=0.
// - T6 Collision: mret_in=1, ecall_in=1 and msip/msie/mie_in=1 in one cycle
//   -> cause_out=0x80000003, mie_set_out stays 0.
//   With stall_in=1 on that cycle -> no action until stall_in=0.

Source files
------------

// File: rtl/trap_ctrl_rv32_if.sv
// Boundary-instruction and CSR-side signals of the RV32 machine-mode trap sequencer.
// The slave modport is the sequencer; the master modport is the pipeline/CSR side driving it.
interface trap_ctrl_rv32_if;
  logic        instr_valid_in;
  logic        stall_in;
  logic [31:0] pc_in;
  logic [31:0] mtvec_in;
  logic        mie_in;
  logic        meie_in, msie_in, mtie_in;
  logic        meip_in, msip_in, mtip_in;
  logic        illegal_in, ecall_in, ebreak_in, ialign_in, lalign_in, salign_in;
  logic        mret_in;
  logic [31:0] mepc_in;

  logic        mie_clear_out;
  logic        mie_set_out;
  logic        cause_we_out;
  logic [31:0] cause_out;
  logic        epc_we_out;
  logic [31:0] epc_out;
  logic        redirect_out;
  logic [31:0] redirect_pc_out;
  logic        flush_out;
  logic        busy_out;

  modport master (
    output instr_valid_in, stall_in, pc_in, mtvec_in, mie_in,
           meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in,
           illegal_in, ecall_in, ebreak_in, ialign_in, lalign_in, salign_in,
           mret_in, mepc_in,
    input  mie_clear_out, mie_set_out, cause_we_out, cause_out, epc_we_out, epc_out,
           redirect_out, redirect_pc_out, flush_out, busy_out
  );

  modport slave (
    input  instr_valid_in, stall_in, pc_in, mtvec_in, mie_in,
           meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in,
           illegal_in, ecall_in, ebreak_in, ialign_in, lalign_in, salign_in,
           mret_in, mepc_in,
    output mie_clear_out, mie_set_out, cause_we_out, cause_out, epc_we_out, epc_out,
           redirect_out, redirect_pc_out, flush_out, busy_out
  );
endinterface

// File: rtl/trap_ctrl_rv32.sv
// Machine-mode trap sequencer: arbitrates interrupts, exceptions and MRET at the commit
// boundary and emits registered mstatus/mcause/mepc strobes plus a PC redirect and flush.
module trap_ctrl_rv32 #(
  parameter bit VECTORED   = 1'b0,
  parameter bit MEPC_ALIGN = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  trap_ctrl_rv32_if.slave  bus
);

  typedef enum logic [1:0] {RUN, ENTER, RETURN, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        mie_clear_q, mie_clear_d;
  logic        mie_set_q, mie_set_d;
  logic        cause_we_q, cause_we_d;
  logic        epc_we_q, epc_we_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        irq_mei, irq_msi, irq_mti, irq_take;
  logic [3:0]  irq_code, exc_code;
  logic        exc_any;
  logic        decide;
  logic [31:0] tvec_base, epc_next;
  logic        unused_mtvec_mode;

  assign irq_mei  = bus.meip_in & bus.meie_in;
  assign irq_msi  = bus.msip_in & bus.msie_in;
  assign irq_mti  = bus.mtip_in & bus.mtie_in;
  assign irq_take = bus.mie_in & (irq_mei | irq_msi | irq_mti);
  assign decide   = bus.instr_valid_in & ~bus.stall_in;

  // The mtvec mode bits only select vectoring in software; here VECTORED fixes it.
  assign tvec_base         = {bus.mtvec_in[31:2], 2'b00};
  assign unused_mtvec_mode = ^bus.mtvec_in[1:0];
  assign epc_next          = MEPC_ALIGN ? {bus.pc_in[31:2], 2'b00} : bus.pc_in;

  // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
  always_comb begin
    irq_code = 4'd7;
    if (irq_mei)      irq_code = 4'd11;
    else if (irq_msi) irq_code = 4'd3;

    exc_any  = 1'b1;
    exc_code = 4'd0;
    if (bus.ialign_in)       exc_code = 4'd0;
    else if (bus.illegal_in) exc_code = 4'd2;
    else if (bus.ebreak_in)  exc_code = 4'd3;
    else if (bus.ecall_in)   exc_code = 4'd11;
    else if (bus.lalign_in)  exc_code = 4'd4;
    else if (bus.salign_in)  exc_code = 4'd6;
    else                     exc_any  = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;
    mie_clear_d   = 1'b0;
    mie_set_d     = 1'b0;
    cause_we_d    = 1'b0;
    epc_we_d      = 1'b0;
    redirect_d    = 1'b0;
    flush_d       = 1'b0;
    busy_d        = 1'b0;

    case (state_q)
      RUN: begin
        if (decide && (irq_take || exc_any)) begin
          state_d     = ENTER;
          mie_clear_d = 1'b1;
          cause_we_d  = 1'b1;
          epc_we_d    = 1'b1;
          redirect_d  = 1'b1;
          flush_d     = 1'b1;
          busy_d      = 1'b1;
          epc_d       = epc_next;
          cause_d     = irq_take ? {1'b1, 27'b0, irq_code} : {28'b0, exc_code};
          redirect_pc_d = (irq_take && VECTORED) ? tvec_base + {26'b0, irq_code, 2'b00}
                                                 : tvec_base;
        end else if (decide && bus.mret_in) begin
          // An interrupt or exception on the same boundary pre-empts MRET above.
          state_d       = RETURN;
          mie_set_d     = 1'b1;
          redirect_d    = 1'b1;
          flush_d       = 1'b1;
          busy_d        = 1'b1;
          redirect_pc_d = bus.mepc_in;
        end
      end
      ENTER, RETURN: begin
        state_d = DRAIN;
        busy_d  = 1'b1;
      end
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state is assigned with <= only, so all flops update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= RUN;
      mie_clear_q   <= 1'b0;
      mie_set_q     <= 1'b0;
      cause_we_q    <= 1'b0;
      epc_we_q      <= 1'b0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mie_clear_q   <= mie_clear_d;
      mie_set_q     <= mie_set_d;
      cause_we_q    <= cause_we_d;
      epc_we_q      <= epc_we_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.mie_clear_out   = mie_clear_q;
  assign bus.mie_set_out     = mie_set_q;
  assign bus.cause_we_out    = cause_we_q;
  assign bus.cause_out       = cause_q;
  assign bus.epc_we_out      = epc_we_q;
  assign bus.epc_out         = epc_q;
  assign bus.redirect_out    = redirect_q;
  assign bus.redirect_pc_out = redirect_pc_q;
  assign bus.flush_out       = flush_q;
  assign bus.busy_out        = busy_q;

endmodule

// File: tb/tb_trap_ctrl_rv32.sv
// Self-checking bench for trap_ctrl_rv32: a direct-mode and a vectored instance share one
// stimulus stream and are compared against a priority-list reference model.
module tb_trap_ctrl_rv32;

  typedef struct packed {
    logic        valid, stall;
    logic [31:0] pc, mtvec, mepc;
    logic        mie, meie, msie, mtie, meip, msip, mtip;
    logic        illegal, ecall, ebreak, ialign, lalign, salign, mret;
  } stim_t;

  typedef struct packed {
    logic        mie_clear, mie_set, cause_we, epc_we, redirect, flush, busy;
    logic [31:0] cause, epc, rpc;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst_in = 1'b0;
  stim_t cur = '0;
  obs_t  obs_b, obs_v, prev_b, prev_v;
  int    tests_run = 0;
  int    failed = 0;

  always #5 clk = ~clk;

  trap_ctrl_rv32_if bus_b ();
  trap_ctrl_rv32_if bus_v ();

  assign bus_b.instr_valid_in = cur.valid;   assign bus_v.instr_valid_in = cur.valid;
  assign bus_b.stall_in       = cur.stall;   assign bus_v.stall_in       = cur.stall;
  assign bus_b.pc_in          = cur.pc;      assign bus_v.pc_in          = cur.pc;
  assign bus_b.mtvec_in       = cur.mtvec;   assign bus_v.mtvec_in       = cur.mtvec;
  assign bus_b.mepc_in        = cur.mepc;    assign bus_v.mepc_in        = cur.mepc;
  assign bus_b.mie_in         = cur.mie;     assign bus_v.mie_in         = cur.mie;
  assign bus_b.meie_in        = cur.meie;    assign bus_v.meie_in        = cur.meie;
  assign bus_b.msie_in        = cur.msie;    assign bus_v.msie_in        = cur.msie;
  assign bus_b.mtie_in        = cur.mtie;    assign bus_v.mtie_in        = cur.mtie;
  assign bus_b.meip_in        = cur.meip;    assign bus_v.meip_in        = cur.meip;
  assign bus_b.msip_in        = cur.msip;    assign bus_v.msip_in        = cur.msip;
  assign bus_b.mtip_in        = cur.mtip;    assign bus_v.mtip_in        = cur.mtip;
  assign bus_b.illegal_in     = cur.illegal; assign bus_v.illegal_in     = cur.illegal;
  assign bus_b.ecall_in       = cur.ecall;   assign bus_v.ecall_in       = cur.ecall;
  assign bus_b.ebreak_in      = cur.ebreak;  assign bus_v.ebreak_in      = cur.ebreak;
  assign bus_b.ialign_in      = cur.ialign;  assign bus_v.ialign_in      = cur.ialign;
  assign bus_b.lalign_in      = cur.lalign;  assign bus_v.lalign_in      = cur.lalign;
  assign bus_b.salign_in      = cur.salign;  assign bus_v.salign_in      = cur.salign;
  assign bus_b.mret_in        = cur.mret;    assign bus_v.mret_in        = cur.mret;

  assign obs_b = {bus_b.mie_clear_out, bus_b.mie_set_out, bus_b.cause_we_out, bus_b.epc_we_out,
                  bus_b.redirect_out, bus_b.flush_out, bus_b.busy_out,
                  bus_b.cause_out, bus_b.epc_out, bus_b.redirect_pc_out};
  assign obs_v = {bus_v.mie_clear_out, bus_v.mie_set_out, bus_v.cause_we_out, bus_v.epc_we_out,
                  bus_v.redirect_out, bus_v.flush_out, bus_v.busy_out,
                  bus_v.cause_out, bus_v.epc_out, bus_v.redirect_pc_out};

  trap_ctrl_rv32 #(.VECTORED(1'b0), .MEPC_ALIGN(1'b1)) dut_b (
    .clk_in (clk), .rst_in (rst_in), .bus (bus_b.slave));
  trap_ctrl_rv32 #(.VECTORED(1'b1), .MEPC_ALIGN(1'b1)) dut_v (
    .clk_in (clk), .rst_in (rst_in), .bus (bus_v.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input obs_t e, input bit chk_rpc);
    check({tag, ".mie_clear"}, 32'(o.mie_clear), 32'(e.mie_clear));
    check({tag, ".mie_set"},   32'(o.mie_set),   32'(e.mie_set));
    check({tag, ".cause_we"},  32'(o.cause_we),  32'(e.cause_we));
    check({tag, ".epc_we"},    32'(o.epc_we),    32'(e.epc_we));
    check({tag, ".redirect"},  32'(o.redirect),  32'(e.redirect));
    check({tag, ".flush"},     32'(o.flush),     32'(e.flush));
    check({tag, ".busy"},      32'(o.busy),      32'(e.busy));
    check({tag, ".cause"},     o.cause,          e.cause);
    check({tag, ".epc"},       o.epc,            e.epc);
    if (chk_rpc || e.redirect) check({tag, ".rpc"}, o.rpc, e.rpc);
  endtask

  // Reference: walk the architectural priority lists; the first enabled source wins.
  function automatic obs_t ref_step(input stim_t s, input bit vec, input obs_t prev);
    obs_t e;
    int   irq_codes [3];
    bit   irq_hit [3];
    int   exc_codes [6];
    bit   exc_hit [6];
    int   code;
    bit   is_irq;
    e = '0;
    e.cause = prev.cause;
    e.epc   = prev.epc;
    e.rpc   = prev.rpc;
    if (!s.valid || s.stall) return e;
    irq_codes = '{11, 3, 7};
    irq_hit   = '{s.meip && s.meie, s.msip && s.msie, s.mtip && s.mtie};
    exc_codes = '{0, 2, 3, 11, 4, 6};
    exc_hit   = '{s.ialign, s.illegal, s.ebreak, s.ecall, s.lalign, s.salign};
    code   = -1;
    is_irq = 1'b0;
    if (s.mie)
      for (int i = 0; i < 3; i++)
        if (irq_hit[i] && code < 0) begin code = irq_codes[i]; is_irq = 1'b1; end
    for (int i = 0; i < 6; i++)
      if (exc_hit[i] && code < 0) code = exc_codes[i];
    if (code >= 0) begin
      {e.mie_clear, e.cause_we, e.epc_we, e.redirect, e.flush, e.busy} = 6'b111111;
      e.cause = is_irq ? 32'h8000_0000 + 32'(code) : 32'(code);
      e.epc   = s.pc & ~32'h3;
      e.rpc   = (s.mtvec & ~32'h3) + ((is_irq && vec) ? 32'(4 * code) : 32'h0);
    end else if (s.mret) begin
      {e.mie_set, e.redirect, e.flush, e.busy} = 4'b1111;
      e.rpc = s.mepc;
    end
    return e;
  endfunction

  function automatic obs_t held(input obs_t p, input bit busy);
    obs_t e;
    e = '0;
    e.cause = p.cause;
    e.epc   = p.epc;
    e.rpc   = p.rpc;
    e.busy  = busy;
    return e;
  endfunction

  function automatic bit coin(input int unsigned n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = !coin(8);   s.stall = coin(8);
    s.pc    = $urandom;   s.mtvec = $urandom;  s.mepc = $urandom;
    s.mie   = coin(2);
    s.meie  = coin(2);    s.msie  = coin(2);   s.mtie = coin(2);
    s.meip  = coin(3);    s.msip  = coin(3);   s.mtip = coin(3);
    s.illegal = coin(5);  s.ecall = coin(5);   s.ebreak = coin(5);
    s.ialign  = coin(6);  s.lalign = coin(5);  s.salign = coin(5);
    s.mret    = coin(3);
    return s;
  endfunction

  // One boundary decision, then (if a sequence starts) its drain and the return to RUN.
  task automatic run_case(input string tag, input stim_t s);
    obs_t eb, ev;
    eb = ref_step(s, 1'b0, prev_b);
    ev = ref_step(s, 1'b1, prev_v);
    cur = s;
    @(posedge clk); @(negedge clk);
    check_obs({tag, "/b"}, obs_b, eb, 1'b0);
    check_obs({tag, "/v"}, obs_v, ev, 1'b0);
    prev_b = eb;
    prev_v = ev;
    if (eb.busy) begin
      cur = rand_stim();
      @(posedge clk); @(negedge clk);
      check_obs({tag, "/drain_b"}, obs_b, held(prev_b, 1'b1), 1'b0);
      check_obs({tag, "/drain_v"}, obs_v, held(prev_v, 1'b1), 1'b0);
      cur = rand_stim();
      @(posedge clk); @(negedge clk);
      check_obs({tag, "/run_b"}, obs_b, held(prev_b, 1'b0), 1'b0);
      check_obs({tag, "/run_v"}, obs_v, held(prev_v, 1'b0), 1'b0);
    end
    cur = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    prev_b = '0;
    prev_v = '0;

    #1;
    check_obs("reset/b", obs_b, '0, 1'b1);
    check_obs("reset/v", obs_v, '0, 1'b1);
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk);
    check_obs("post_reset/b", obs_b, '0, 1'b1);

    // Timer interrupt, direct mode on dut_b.
    s = '0; s.valid = 1; s.mie = 1; s.mtie = 1; s.mtip = 1; s.pc = 32'h100; s.mtvec = 32'h800;
    run_case("t2_mti", s);
    check("t2_cause_held", obs_b.cause, 32'h8000_0007);
    check("t2_epc_held",   obs_b.epc,   32'h0000_0100);

    // Vectored external interrupt: 0x800 + 4*11 on dut_v.
    s = '0; s.valid = 1; s.mie = 1; s.meie = 1; s.meip = 1; s.pc = 32'h200; s.mtvec = 32'h801;
    run_case("t3_mei", s);
    check("t3_cause_held", obs_v.cause, 32'h8000_000B);

    // Illegal instruction inside a handler, with a masked timer interrupt pending.
    s = '0; s.valid = 1; s.illegal = 1; s.pc = 32'h44; s.mtvec = 32'h800; s.mtie = 1; s.mtip = 1;
    run_case("t4_illegal", s);
    check("t4_cause_held", obs_b.cause, 32'h2);
    check("t4_epc_held",   obs_b.epc,   32'h44);

    // MRET.
    s = '0; s.valid = 1; s.mret = 1; s.mepc = 32'h104; s.mtvec = 32'h800;
    run_case("t5_mret", s);

    // Pending interrupt while masked: no action, then taken once enabled.
    s = '0; s.valid = 1; s.msie = 1; s.msip = 1; s.pc = 32'h300; s.mtvec = 32'h900;
    run_case("masked_irq", s);
    s.mie = 1;
    run_case("unmasked_irq", s);

    // Collision: MSI beats ECALL and MRET; first held off by stall.
    s = '0; s.valid = 1; s.stall = 1; s.mret = 1; s.ecall = 1; s.mie = 1; s.msie = 1; s.msip = 1;
    s.pc = 32'h408; s.mtvec = 32'h1000; s.mepc = 32'h500;
    for (int i = 0; i < 3; i++) run_case("t6_stalled", s);
    s.stall = 0;
    run_case("t6_collide", s);
    check("t6_cause_held", obs_b.cause, 32'h8000_0003);

    // Asynchronous reset in the middle of ENTER.
    s = '0; s.valid = 1; s.ecall = 1; s.pc = 32'h600; s.mtvec = 32'h800;
    cur = s;
    @(posedge clk); @(negedge clk);
    check("rst_mid_enter_pre", 32'(obs_b.mie_clear), 32'h1);
    rst_in = 1'b0;
    #1;
    check_obs("rst_mid_enter/b", obs_b, '0, 1'b1);
    check_obs("rst_mid_enter/v", obs_v, '0, 1'b1);
    prev_b = '0;
    prev_v = '0;
    cur = '0;
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk);
    check_obs("rst_release/b", obs_b, '0, 1'b1);
    s = '0; s.valid = 1; s.salign = 1; s.lalign = 1; s.pc = 32'h7FE; s.mtvec = 32'hC00;
    run_case("after_reset", s);

    for (int i = 0; i < 60; i++) run_case($sformatf("rand%0d", i), rand_stim());

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
